// File: rtl/block_tx_sequencer.sv
// Block-to-byte sequencer: accepts a cipher block and feeds it MSB-first, one byte at a time,
// to a serial transmitter, pacing on its done pulse with a timeout abort.
module block_tx_sequencer #(
    parameter int unsigned BLOCK_BYTES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_Block_Valid,
    input  logic [8*BLOCK_BYTES-1:0] i_Block,
    output logic                     o_Block_Ready,
    output logic                     o_Tx_DV,
    output logic [7:0]               o_Tx_Byte,
    input  logic                     i_Tx_Active,
    input  logic                     i_Tx_Done,
    output logic                     o_Busy,
    output logic                     o_Block_Sent,
    output logic                     o_Error
);

    localparam int unsigned BW = 8 * BLOCK_BYTES;
    localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP,
        ST_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          gap_q, gap_d;
    logic          ready_q, ready_d;
    logic          dv_q, dv_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          busy_q, busy_d;
    logic          sent_q, sent_d;
    logic          error_q, error_d;

    // Transmitter busy flag is informational only; pacing relies solely on i_Tx_Done.
    logic unused_tx_active;
    assign unused_tx_active = i_Tx_Active;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        error_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Block_Valid) begin
                    shreg_d    = i_Block;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is checked first so a done on the final allowed cycle beats the timeout.
                if (i_Tx_Done) begin
                    byte_cnt_d = byte_cnt_q + CW'(1);
                    shreg_d    = shreg_q << 8;
                    gap_d      = 1'b0;
                    state_d    = (byte_cnt_q == LAST_BYTE) ? ST_FINISH : ST_GAP;
                end else if (tmo_q == TMO_LIMIT) begin
                    error_d = 1'b1;
                    shreg_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with the state.
        ready_d   = (state_d == ST_IDLE);
        dv_d      = (state_d == ST_SEND);
        busy_d    = (state_d != ST_IDLE);
        sent_d    = (state_d == ST_FINISH);
        tx_byte_d = dv_d ? shreg_d[BW-1 -: 8] : tx_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            gap_q      <= 1'b0;
            ready_q    <= 1'b0;
            dv_q       <= 1'b0;
            tx_byte_q  <= '0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            ready_q    <= ready_d;
            dv_q       <= dv_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            error_q    <= error_d;
        end
    end

    assign o_Block_Ready = ready_q;
    assign o_Tx_DV       = dv_q;
    assign o_Tx_Byte     = tx_byte_q;
    assign o_Busy        = busy_q;
    assign o_Block_Sent  = sent_q;
    assign o_Error       = error_q;

endmodule

// File: doc/block_tx_sequencer.md
BLOCK_TX_SEQUENCER -- requirements
Module: block_tx_sequencer

Interface
REQ-001 Parameter BLOCK_BYTES, default 8: bytes per cipher block; legal range 1..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 2048: maximum cycles to wait for a byte's done pulse; legal range 16..65535.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous, release is synchronous to clk.
REQ-005 i_Block_Valid  input  1  upstream (cipher core) presents a block.
REQ-006 i_Block  input  8*BLOCK_BYTES  block to transmit; sampled only at handshake.
REQ-007 o_Block_Ready  output  1  block sequencer can accept a block.
REQ-008 o_Tx_DV  output  1  one-cycle byte-valid strobe to the serial transmitter.
REQ-009 o_Tx_Byte  output  8  byte to the serial transmitter; stable from the o_Tx_DV cycle until the matching i_Tx_Done.
REQ-010 i_Tx_Active  input  1  serial transmitter busy flag.
REQ-011 i_Tx_Done  input  1  serial transmitter one-cycle end-of-byte pulse.
REQ-012 o_Busy  output  1  high whenever the state is not IDLE.
REQ-013 o_Block_Sent  output  1  one-cycle pulse when the last byte completes.
REQ-014 o_Error  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 The block SHALL use FSM states IDLE, SEND, WAIT, GAP, FINISH.
REQ-016 IDLE: o_Block_Ready=1; on i_Block_Valid=1 at an edge, the block SHALL capture i_Block into a shift register, clear the byte counter, and go to SEND.
REQ-017 i_Block_Valid while o_Block_Ready=0 SHALL be ignored; the block SHALL NOT queue it.
REQ-018 SEND: o_Tx_DV=1 for exactly one cycle; o_Tx_Byte = current most-significant byte; next state WAIT; the timeout counter SHALL clear.
REQ-019 Byte order SHALL be MSB first: i_Block[8*BLOCK_BYTES-1 -: 8] is sent first, i_Block[7:0] last.
REQ-020 WAIT: the timeout counter SHALL increment each cycle; on i_Tx_Done=1, the byte counter SHALL increment, the shift register SHALL shift left by 8, and the state SHALL go to FINISH if this was byte BLOCK_BYTES-1, otherwise to GAP.
REQ-021 GAP: the FSM SHALL hold exactly 2 cycles, then go to SEND, guaranteeing the downstream transmitter has returned to idle before the next strobe.
REQ-022 FINISH: o_Block_Sent=1 for one cycle; next state IDLE.
REQ-023 Timeout: if WAIT sees no i_Tx_Done within TIMEOUT_CYCLES cycles, o_Error SHALL pulse for one cycle, the remaining bytes SHALL be discarded, and the state SHALL go to IDLE; o_Block_Sent SHALL NOT pulse.
REQ-024 i_Tx_Done and the timeout limit in the same cycle: Done SHALL win; there is no error.
REQ-025 i_Tx_Done outside WAIT SHALL be ignored.
REQ-026 i_Tx_Active is status only; it SHALL NOT gate transitions.
REQ-027 The byte counter SHALL be ceil(log2(BLOCK_BYTES+1)) bits and SHALL never wrap within a block.
REQ-028 Back-to-back blocks: o_Block_Ready SHALL reassert the cycle after FINISH, so there is at least one IDLE cycle between blocks.
REQ-029 o_Tx_DV SHALL never assert in two consecutive cycles.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 On rst_n=0: state=IDLE, o_Block_Ready=0 while in reset and 1 from the first edge after release, and o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Block_Sent=0, o_Error=0; counters and the shift register SHALL clear.
REQ-032 Reset mid-block SHALL discard the block immediately; neither o_Block_Sent nor o_Error SHALL pulse.

Verification
REQ-033 Load 64'h0123456789ABCDEF, model the transmitter with Done 870 cycles after each DV -> o_Tx_Byte sequence 01,23,45,67,89,AB,CD,EF; 8 DV pulses; one o_Block_Sent after the 8th Done.
REQ-034 Done never returns after byte 3 -> o_Error pulses exactly 2048 cycles after entering WAIT; no o_Block_Sent; o_Block_Ready returns to 1.
REQ-035 i_Block_Valid held high with a second block during transmission -> the second block is accepted only after FINISH, and byte 0 of block 2 follows the last byte of block 1.
REQ-036 rst_n pulsed low during byte 5 -> all outputs at reset values asynchronously; the next block restarts from byte 0.
REQ-037 Spurious i_Tx_Done in IDLE and GAP -> no state or counter change; the gap between Done and the next DV is exactly 3 cycles.
REQ-038 BLOCK_BYTES=1, i_Block=8'hA5 -> a single DV with byte A5, then o_Block_Sent.
